// File: rtl/uop_sequencer.sv
// uop_sequencer: issues the 1..3 decoded micro-ops of each instruction to
// execution one per cycle over valid/ready, ending with uop_0.
// Ports: clk, a_rst (sync, active-low), hold, flush; decode side feed_req,
// feed_ack, uop_0..uop_2, uop_count; execution side ex_valid, ex_ready,
// ex_uop, ex_first, ex_last; status busy, inst_count.
module uop_sequencer #(
  parameter int UOP_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             hold,
  input  logic             flush,
  output logic             feed_req,
  input  logic             feed_ack,
  input  logic [UOP_W-1:0] uop_0,
  input  logic [UOP_W-1:0] uop_1,
  input  logic [UOP_W-1:0] uop_2,
  input  logic [1:0]       uop_count,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [UOP_W-1:0] ex_uop,
  output logic             ex_first,
  output logic             ex_last,
  output logic             busy,
  output logic [CNT_W-1:0] inst_count
);

  // State encoding equals the number of micro-ops still to issue.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ISS0  = 2'd1,
    ISS1  = 2'd2,
    ISS2  = 2'd3
  } state_t;

  state_t           remaining;
  logic [UOP_W-1:0] slot0;
  logic [UOP_W-1:0] slot1;
  logic [UOP_W-1:0] slot2;
  logic [1:0]       first_len;
  logic [1:0]       cap_len;
  logic             issue;
  logic             capture;

  assign busy     = (remaining != EMPTY);
  assign ex_valid = busy & ~hold;
  assign ex_last  = (remaining == ISS0);
  // first_len is never 0 after a capture, so the busy gate keeps
  // ex_first low out of reset.
  assign ex_first = busy & (remaining == first_len);
  assign issue    = ex_valid & ex_ready;

  // Accept a new instruction when idle, or when the final micro-op of
  // the current one leaves this cycle (zero-bubble hand-over).
  assign feed_req = a_rst & ~hold & ~flush &
                    ((remaining == EMPTY) |
                     ((remaining == ISS0) & ex_ready));
  assign capture  = feed_req & feed_ack;

  // uop_count of 3 is treated as 2 (three micro-ops).
  assign cap_len = (uop_count == 2'd3) ? 2'd3 : uop_count + 2'd1;

  always_comb begin
    ex_uop = slot0;
    unique case (remaining)
      ISS2:    ex_uop = slot2;
      ISS1:    ex_uop = slot1;
      default: ex_uop = slot0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      remaining  <= EMPTY;
      slot0      <= '0;
      slot1      <= '0;
      slot2      <= '0;
      first_len  <= 2'd0;
      inst_count <= '0;
    end else if (flush) begin
      // An issue accepted alongside the flush still retires.
      if (issue && ex_last) begin
        inst_count <= inst_count + CNT_W'(1);
      end
      remaining <= EMPTY;
    end else if (!hold) begin
      if (issue && ex_last) begin
        inst_count <= inst_count + CNT_W'(1);
      end
      if (capture) begin
        slot0     <= uop_0;
        slot1     <= uop_1;
        slot2     <= uop_2;
        first_len <= cap_len;
        remaining <= state_t'(cap_len);
      end else if (issue) begin
        remaining <= state_t'(remaining - 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: directed scenario tasks plus a randomized run checked
// against a queue-based model of the micro-op stream.
module tb_uop_sequencer;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        hold;
  logic        flush;
  logic        feed_req;
  logic        feed_ack;
  logic [19:0] uop_0;
  logic [19:0] uop_1;
  logic [19:0] uop_2;
  logic [1:0]  uop_count;
  logic        ex_valid;
  logic        ex_ready;
  logic [19:0] ex_uop;
  logic        ex_first;
  logic        ex_last;
  logic        busy;
  logic [15:0] inst_count;

  int checks  = 0;
  int fails   = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [19:0] uop;
    logic        first;
    logic        last;
  } ent_t;

  uop_sequencer #(.UOP_W(20), .CNT_W(16)) dut (
    .clk(clk), .a_rst(a_rst), .hold(hold), .flush(flush),
    .feed_req(feed_req), .feed_ack(feed_ack),
    .uop_0(uop_0), .uop_1(uop_1), .uop_2(uop_2),
    .uop_count(uop_count), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_uop(ex_uop),
    .ex_first(ex_first), .ex_last(ex_last),
    .busy(busy), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_idle;
    hold = 0; flush = 0; feed_ack = 0; ex_ready = 0;
  endtask

  task automatic load(input logic [1:0] c);
    uop_0 = 20'($urandom);
    uop_1 = 20'($urandom);
    uop_2 = 20'($urandom);
    uop_count = c;
  endtask

  task automatic test_reset;
    a_rst = 0; set_idle();
    uop_0 = 0; uop_1 = 0; uop_2 = 0; uop_count = 0;
    tick(); tick(); #1;
    checks++; if (feed_req !== 1'b0) begin fails++;
      $display("FAIL rst_feed_req got=%b exp=0", feed_req); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (ex_valid !== 1'b0) begin fails++;
      $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_first !== 1'b0 || ex_last !== 1'b0) begin fails++;
      $display("FAIL rst_first_last got=%b%b exp=00", ex_first, ex_last); end
    checks++; if (inst_count !== 16'd0) begin fails++;
      $display("FAIL rst_inst_count got=%0d exp=0", inst_count); end
    tick();
    a_rst = 1; #1;
    checks++; if (feed_req !== 1'b1) begin fails++;
      $display("FAIL rst_release_req got=%b exp=1", feed_req); end
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_three_uop;
    logic [19:0] e [3];
    set_idle();
    e[0] = 20'h20002; e[1] = 20'h10001; e[2] = 20'h00000;
    uop_2 = e[0]; uop_1 = e[1]; uop_0 = e[2]; uop_count = 2;
    feed_ack = 1; ex_ready = 1; #1;
    checks++; if (feed_req !== 1'b1) begin fails++;
      $display("FAIL t3_feed_req got=%b exp=1", feed_req); end
    tick(); feed_ack = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ex_valid !== 1'b1 || ex_uop !== e[k] ||
          ex_first !== (k == 0) || ex_last !== (k == 2)) begin
        fails++;
        $display("FAIL t3_issue%0d got v=%b u=%h f=%b l=%b exp u=%h",
                 k, ex_valid, ex_uop, ex_first, ex_last, e[k]);
      end
      tick();
    end
    exp_cnt++; #1;
    checks++; if (busy !== 1'b0 || inst_count !== 16'(exp_cnt)) begin
      fails++;
      $display("FAIL t3_done got busy=%b cnt=%0d exp busy=0 cnt=%0d",
               busy, inst_count, exp_cnt); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [19:0] u [4][3];
    int cnts [4];
    logic [19:0] eq [$];
    int i = 0, issued = 0, first_cyc = -1, last_cyc = -1;
    cnts[0] = 0; cnts[1] = 1; cnts[2] = 2; cnts[3] = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 3; b++) u[a][b] = 20'($urandom);
    for (int a = 0; a < 4; a++)
      for (int b = cnts[a]; b >= 0; b--) eq.push_back(u[a][b]);
    set_idle(); ex_ready = 1;
    for (int cyc = 0; cyc < 30 && issued < 7; cyc++) begin
      if (i < 4) begin
        uop_0 = u[i][0]; uop_1 = u[i][1]; uop_2 = u[i][2];
        uop_count = 2'(cnts[i]); feed_ack = 1;
      end else feed_ack = 0;
      #1;
      if (ex_valid) begin
        checks++;
        if (ex_uop !== eq[issued]) begin fails++;
          $display("FAIL b2b_uop%0d got=%h exp=%h",
                   issued, ex_uop, eq[issued]); end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        issued++;
      end
      if (feed_req && feed_ack) i++;
      tick();
    end
    feed_ack = 0;
    checks++; if (issued != 7) begin fails++;
      $display("FAIL b2b_count got=%0d exp=7", issued); end
    checks++; if (last_cyc - first_cyc != 6) begin fails++;
      $display("FAIL b2b_span got=%0d exp=6", last_cyc - first_cyc); end
    exp_cnt += 4; #1;
    checks++; if (inst_count !== 16'(exp_cnt)) begin fails++;
      $display("FAIL b2b_inst_count got=%0d exp=%0d", inst_count, exp_cnt); end
    tick();
  endtask

  task automatic test_backpressure;
    logic [19:0] a0, a1;
    set_idle(); load(2'd1); a0 = uop_0; a1 = uop_1;
    feed_ack = 1; tick(); feed_ack = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ex_valid !== 1'b1 || ex_uop !== a1 || feed_req !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall%0d got v=%b u=%h req=%b exp v=1 u=%h req=0",
                 k, ex_valid, ex_uop, feed_req, a1);
      end
      tick();
    end
    ex_ready = 1; #1;
    checks++; if (ex_uop !== a1 || ex_first !== 1'b1) begin fails++;
      $display("FAIL bp_uop1 got u=%h f=%b exp u=%h f=1", ex_uop, ex_first, a1); end
    tick(); #1;
    checks++; if (ex_uop !== a0 || ex_last !== 1'b1) begin fails++;
      $display("FAIL bp_uop0 got u=%h l=%b exp u=%h l=1", ex_uop, ex_last, a0); end
    tick(); exp_cnt++; #1;
    checks++; if (busy !== 1'b0 || inst_count !== 16'(exp_cnt)) begin fails++;
      $display("FAIL bp_done got busy=%b cnt=%0d exp 0/%0d",
               busy, inst_count, exp_cnt); end
    tick();
  endtask

  task automatic test_flush;
    logic [19:0] a1;
    set_idle(); load(2'd2); a1 = uop_1;
    feed_ack = 1; ex_ready = 1; tick(); feed_ack = 0;
    tick();
    flush = 1; feed_ack = 1; load(2'd2); #1;
    checks++; if (feed_req !== 1'b0 || ex_uop !== a1) begin fails++;
      $display("FAIL fl_cycle got req=%b u=%h exp req=0 u=%h",
               feed_req, ex_uop, a1); end
    tick(); flush = 0; feed_ack = 0; #1;
    checks++; if (busy !== 1'b0 || ex_valid !== 1'b0) begin fails++;
      $display("FAIL fl_empty got busy=%b v=%b exp 0/0", busy, ex_valid); end
    checks++; if (inst_count !== 16'(exp_cnt)) begin fails++;
      $display("FAIL fl_inst_count got=%0d exp=%0d", inst_count, exp_cnt); end
    tick();
  endtask

  task automatic test_hold;
    logic [19:0] a0, a1;
    set_idle(); load(2'd2); a0 = uop_0; a1 = uop_1;
    feed_ack = 1; ex_ready = 1; tick(); feed_ack = 0;
    tick();
    hold = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (ex_valid !== 1'b0 || feed_req !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold%0d got v=%b req=%b busy=%b exp 0/0/1",
                 k, ex_valid, feed_req, busy);
      end
      tick();
    end
    hold = 0; #1;
    checks++; if (ex_valid !== 1'b1 || ex_uop !== a1) begin fails++;
      $display("FAIL hold_resume got v=%b u=%h exp v=1 u=%h", ex_valid, ex_uop, a1); end
    tick(); #1;
    checks++; if (ex_uop !== a0 || ex_last !== 1'b1) begin fails++;
      $display("FAIL hold_last got u=%h l=%b exp u=%h", ex_uop, ex_last, a0); end
    tick(); exp_cnt++; #1;
    checks++; if (inst_count !== 16'(exp_cnt)) begin fails++;
      $display("FAIL hold_inst_count got=%0d exp=%0d", inst_count, exp_cnt); end
    tick();
  endtask

  task automatic test_count3_reset;
    logic [19:0] e [3];
    set_idle(); load(2'd3);
    e[0] = uop_2; e[1] = uop_1; e[2] = uop_0;
    feed_ack = 1; ex_ready = 1; tick(); feed_ack = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ex_valid !== 1'b1 || ex_uop !== e[k] ||
          ex_first !== (k == 0) || ex_last !== (k == 2)) begin
        fails++;
        $display("FAIL c3_issue%0d got u=%h f=%b l=%b exp u=%h",
                 k, ex_uop, ex_first, ex_last, e[k]);
      end
      tick();
    end
    exp_cnt++; #1;
    checks++; if (busy !== 1'b0 || inst_count !== 16'(exp_cnt)) begin fails++;
      $display("FAIL c3_done got busy=%b cnt=%0d exp 0/%0d",
               busy, inst_count, exp_cnt); end
    set_idle(); load(2'd2); feed_ack = 1; tick(); feed_ack = 0; #1;
    checks++; if (busy !== 1'b1) begin fails++;
      $display("FAIL mr_busy got=%b exp=1", busy); end
    a_rst = 0; tick(); a_rst = 1; #1;
    exp_cnt = 0;
    checks++; if (busy !== 1'b0 || ex_valid !== 1'b0 || inst_count !== 16'd0) begin
      fails++;
      $display("FAIL mr_after got busy=%b v=%b cnt=%0d exp 0/0/0",
               busy, ex_valid, inst_count); end
    ex_ready = 1; tick(); #1;
    checks++; if (busy !== 1'b0 || ex_valid !== 1'b0) begin fails++;
      $display("FAIL mr_quiet got busy=%b v=%b exp 0/0", busy, ex_valid); end
    tick();
  endtask

  task automatic test_random;
    ent_t        mq [$];
    ent_t        e;
    logic [19:0] ua [3];
    logic        mreq, iss;
    int          mcnt, n;
    mcnt = exp_cnt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_rst    = ($urandom_range(0, 63) != 0);
      hold     = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      load(2'($urandom));
      mreq = a_rst && !hold && !flush &&
             (mq.size() == 0 || (mq.size() == 1 && ex_ready));
      feed_ack = mreq && ($urandom_range(0, 1) == 1);
      #1;
      checks++; if (feed_req !== mreq) begin fails++;
        $display("FAIL rnd_feed_req c%0d got=%b exp=%b", cyc, feed_req, mreq); end
      checks++;
      if (ex_valid !== (mq.size() != 0 && !hold) ||
          busy !== (mq.size() != 0)) begin fails++;
        $display("FAIL rnd_valid_busy c%0d got v=%b b=%b exp q=%0d h=%b",
                 cyc, ex_valid, busy, mq.size(), hold); end
      if (mq.size() != 0) begin
        checks++;
        if (ex_uop !== mq[0].uop || ex_first !== mq[0].first ||
            ex_last !== mq[0].last) begin fails++;
          $display("FAIL rnd_uop c%0d got u=%h f=%b l=%b exp u=%h f=%b l=%b",
                   cyc, ex_uop, ex_first, ex_last,
                   mq[0].uop, mq[0].first, mq[0].last); end
      end
      checks++; if (inst_count !== 16'(mcnt)) begin fails++;
        $display("FAIL rnd_inst_count c%0d got=%0d exp=%0d",
                 cyc, inst_count, 16'(mcnt)); end
      iss = (mq.size() != 0) && !hold && ex_ready;
      if (!a_rst) begin
        mq.delete(); mcnt = 0;
      end else if (flush) begin
        if (iss && mq[0].last) mcnt++;
        mq.delete();
      end else if (!hold) begin
        if (iss) begin
          if (mq[0].last) mcnt++;
          void'(mq.pop_front());
        end
        if (feed_ack) begin
          ua[0] = uop_0; ua[1] = uop_1; ua[2] = uop_2;
          n = (uop_count == 2'd3) ? 3 : int'(uop_count) + 1;
          for (int j = n - 1; j >= 0; j--) begin
            e.uop = ua[j]; e.first = (j == n - 1); e.last = (j == 0);
            mq.push_back(e);
          end
        end
      end
      tick();
    end
    a_rst = 1; set_idle();
  endtask

  initial begin
    a_rst = 0;
    set_idle();
    uop_0 = 0; uop_1 = 0; uop_2 = 0; uop_count = 0;
    @(negedge clk);
    test_reset();
    test_three_uop();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_hold();
    test_count3_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/uop_sequencer.md
# uop_sequencer

Micro-op issue sequencer between the decode unit and the execution datapath. It requests instructions from decode through the `feed_req`/`feed_ack` handshake and captures the one to three decoded micro-ops of each instruction. It issues them to execution one per cycle over a valid/ready interface in program order, ending with `uop_0`. It also handles pipeline hold, redirect flush and a retired-instruction counter.

## Interface
- `UOP_W`, 20, micro-op width; must match decode `uop_*` width.
- `CNT_W`, 16, width of the retired-instruction counter.

- `clk`  in  1  clock; all state updates on rising edge.
- `a_rst`  in  1  reset, synchronous, active-low.
- `hold`  in  1  global stall; freezes sequencer state.
- `flush`  in  1  redirect (PC invalidate); discards buffered and incoming micro-ops.
- `feed_req`  out  1  request to decode: sequencer can accept an instruction this cycle.
- `feed_ack`  in  1  decode delivers an instruction this cycle; meaningful only while `feed_req`=1.
- `uop_0`, `uop_1`, `uop_2`  in  UOP_W each  decoded micro-ops, sampled on accepted `feed_ack`.
- `uop_count`  in  2  micro-ops minus one: 0→1 uop, 1→2 uops, 2→3 uops; 3 is treated as 2.
- `ex_valid`  out  1  `ex_uop` holds a valid micro-op.
- `ex_ready`  in  1  execution accepts `ex_uop` this cycle.
- `ex_uop`  out  UOP_W  micro-op being offered.
- `ex_first`  out  1  `ex_uop` is the first micro-op of its instruction.
- `ex_last`  out  1  `ex_uop` is `uop_0`, the final micro-op of its instruction.
- `busy`  out  1  at least one micro-op is buffered.
- `inst_count`  out  CNT_W  instructions fully issued since reset; wraps modulo 2^CNT_W.

## Operation
- Storage: three slot registers `slot0..slot2` plus a 2-bit `remaining` (0..3). The count of remaining micro-ops defines the state:
  - EMPTY: `remaining`=0.
  - ISS2: next micro-op is `slot2`.
  - ISS1: next micro-op is `slot1`.
  - ISS0: next micro-op is `slot0`.
- Issue order is `slot[remaining-1]` down to `slot0`:
  - count 0 issues `uop_0`;
  - count 1 issues `uop_1`, `uop_0`;
  - count 2 issues `uop_2`, `uop_1`, `uop_0`.
- `ex_uop` is `slot[remaining-1]` through a combinational mux, and is `slot0` in EMPTY.
- `ex_valid` = (`remaining`≠0) & ~`hold`.
- `ex_last` = (`remaining`==1).
- `ex_first` = (`remaining` equals the captured count+1). `first_len` is a 2-bit register loaded on capture.
- `busy` = (`remaining`≠0).
- An issue occurs when `ex_valid` & `ex_ready`. It decrements `remaining`.
- `feed_req` = ~`hold` & ~`flush` & (EMPTY | (ISS0 & `ex_ready`)).
- A capture occurs when `feed_req` & `feed_ack`. It loads all three slots and sets `remaining` = min(`uop_count`,2)+1. Capture overrides the decrement when it coincides with the last issue.
- `feed_ack` while `feed_req`=0 is ignored. The bench flags it as a protocol error.
- `inst_count` increments on each issue with `ex_last`=1.
- Priority, highest first: reset, `flush`, `hold`, issue/capture.
  - `flush`: `remaining`←0 next cycle. It also suppresses capture of any instruction acked in the same cycle, because `feed_req` is 0. An issue accepted in the flush cycle still counts toward `inst_count` if it is last.
  - `hold` without `flush`: every register keeps its value; `ex_valid`=0 and `feed_req`=0.

## Timing
- Reset (`a_rst`=0 at a clock edge):
  - `remaining`=0, slots=0, `first_len`=0, `inst_count`=0.
  - Hence `ex_valid`=0, `busy`=0, `ex_first`=0, `ex_last`=0.
  - `feed_req` is forced 0 while `a_rst`=0.
- Reset mid-instruction drops all buffered micro-ops; nothing is issued after release until a new capture.
- Latency: capture in cycle N gives the first micro-op on `ex_valid` in cycle N+1.
- Back-to-back: the last micro-op of instruction A is accepted in cycle N with the capture of B in N, so the first micro-op of B is valid in N+1. There are zero bubbles between instructions.
- Throughput: one micro-op per cycle while `ex_ready`=1.
- Back-pressure: with `ex_ready`=0, `ex_uop`/`ex_valid` stay stable until accepted, unless `hold`/`flush` intervene.
- `hold` asserted in cycle N: `ex_valid`/`feed_req` drop in N combinationally. State resumes unchanged in the cycle after `hold` deasserts.

## Test plan
- Reset, then capture count=2 with `uop_2`=0x20002, `uop_1`=0x10001, `uop_0`=0x00000, `ex_ready`=1 → `ex_uop` 0x20002, 0x10001, 0x00000 in cycles N+1..N+3. `ex_first` only in N+1, `ex_last` only in N+3; `inst_count`=1.
- Continuous decode supply of count 0, 1, 2, 0 with `ex_ready`=1 → 7 micro-ops in 7 consecutive cycles with no gap; `inst_count`=4.
- Count=1 captured, `ex_ready`=0 for 3 cycles → `ex_uop`=`uop_1` stable, `feed_req`=0. Then `ex_ready`=1 → `uop_1`, `uop_0` over 2 cycles.
- `flush` during ISS1 of a 3-uop instruction while decode asserts `feed_ack` → no capture; `busy`=0 next cycle; `inst_count` unchanged.
- `hold` for 2 cycles in ISS1 → `ex_valid`=0 and `feed_req`=0. The next `ex_uop` after release is `slot1`.
- `uop_count`=3 → behaves as 3 micro-ops. `a_rst` asserted in ISS2 → `busy`=0 after the edge and `inst_count`=0.
